// File: rtl/q_tile_sequencer.sv
// q_tile_sequencer
//
// Sequences one projection pass as a series of tiles. For each tile it pulses
// lane_start to all four lanes, waits for the synchronized all-lanes-finished
// pulse (sync_pulse), then idles for GAP_CYC cycles before launching the next
// tile. After the last tile it pulses done. A watchdog abandons the pass and
// raises the sticky timeout_err flag if a tile never completes.
//
// Parameters:
//   CNT_W   - width of the tile count and tile index
//   GAP_CYC - idle cycles between an accepted sync_pulse and the next lane_start (>= 1)
//   TIMEOUT - WAIT-state cycles before a timeout is declared
//
// Ports:
//   clk         - rising-edge clock
//   rst_n       - asynchronous active-low reset
//   start       - single-cycle request to run one pass (ignored while busy)
//   num_tiles   - tiles per pass, sampled only when start is accepted
//   abort       - cancels the pass in progress
//   sync_pulse  - single-cycle all-lanes-finished pulse (only honoured in WAIT)
//   lane_start  - single-cycle launch pulse to all lanes
//   tile_idx    - index of the tile currently issued
//   busy        - high in every state except IDLE
//   done        - single-cycle pass-complete pulse
//   timeout_err - sticky watchdog flag

module q_tile_sequencer #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned GAP_CYC = 2,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_tiles,
    input  logic             abort,
    input  logic             sync_pulse,
    output logic             lane_start,
    output logic [CNT_W-1:0] tile_idx,
    output logic             busy,
    output logic             done,
    output logic             timeout_err
);

    localparam int unsigned WD_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned GAP_W = (GAP_CYC > 2) ? $clog2(GAP_CYC) : 1;

    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StSettle,
        StFinish
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] num_q;
    logic [WD_W-1:0]  wdog_q;
    logic [GAP_W-1:0] gap_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            num_q       <= '0;
            wdog_q      <= '0;
            gap_q       <= '0;
            lane_start  <= 1'b0;
            tile_idx    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            // Pulse outputs default low; only the transitions below raise them.
            lane_start <= 1'b0;
            done       <= 1'b0;

            if (state_q != StIdle && abort) begin
                // Abort beats sync_pulse and the watchdog; tile_idx is kept.
                state_q <= StIdle;
                busy    <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start) begin
                            if (num_tiles != '0) begin
                                num_q       <= num_tiles;
                                tile_idx    <= '0;
                                timeout_err <= 1'b0;
                                lane_start  <= 1'b1;
                                busy        <= 1'b1;
                                state_q     <= StIssue;
                            end else begin
                                // Empty pass completes at once; error flag untouched.
                                done <= 1'b1;
                            end
                        end
                    end

                    StIssue: begin
                        wdog_q  <= '0;
                        state_q <= StWait;
                    end

                    StWait: begin
                        // A completion arriving on the expiry cycle still wins.
                        if (sync_pulse) begin
                            if (tile_idx == num_q - CNT_W'(1)) begin
                                done    <= 1'b1;
                                state_q <= StFinish;
                            end else begin
                                tile_idx <= tile_idx + 1'b1;
                                gap_q    <= '0;
                                state_q  <= StSettle;
                            end
                        end else if (wdog_q == WD_LAST) begin
                            timeout_err <= 1'b1;
                            busy        <= 1'b0;
                            state_q     <= StIdle;
                        end else begin
                            wdog_q <= wdog_q + 1'b1;
                        end
                    end

                    StSettle: begin
                        if (gap_q == GAP_LAST) begin
                            lane_start <= 1'b1;
                            state_q    <= StIssue;
                        end else begin
                            gap_q <= gap_q + 1'b1;
                        end
                    end

                    StFinish: begin
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end

                    default: begin
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_q_tile_sequencer.sv
// Testbench for q_tile_sequencer: directed scenarios with hand-derived
// expectations, followed by a randomized run checked every cycle against an
// event-time reference model (launch/finish cycles computed arithmetically).

module tb_q_tile_sequencer;

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned GAP_CYC = 2;
    localparam int unsigned TIMEOUT = 16;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] num_tiles;
    logic             abort;
    logic             sync_pulse;
    logic             lane_start;
    logic [CNT_W-1:0] tile_idx;
    logic             busy;
    logic             done;
    logic             timeout_err;

    int checks = 0;
    int errors = 0;
    int lane_cnt = 0;
    int done_cnt = 0;

    q_tile_sequencer #(
        .CNT_W  (CNT_W),
        .GAP_CYC(GAP_CYC),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_tiles  (num_tiles),
        .abort      (abort),
        .sync_pulse (sync_pulse),
        .lane_start (lane_start),
        .tile_idx   (tile_idx),
        .busy       (busy),
        .done       (done),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (lane_start === 1'b1) lane_cnt++;
        if (done === 1'b1) done_cnt++;
    end

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic tick(input bit s, input logic [CNT_W-1:0] n, input bit a, input bit y);
        start      = s;
        num_tiles  = n;
        abort      = a;
        sync_pulse = y;
        @(posedge clk);
        #1;
        start      = 1'b0;
        abort      = 1'b0;
        sync_pulse = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b0, 1'b0);
    endtask

    // ------------------------------------------------------------------
    // Reference model: tracks the cycle numbers at which lane_start and
    // done are due, rather than a state register.
    // ------------------------------------------------------------------
    int m_c, m_num, m_idx, m_launch, m_finish, m_zdone;
    bit m_act, m_terr;

    function automatic void m_reset();
        m_c = 0; m_act = 0; m_num = 0; m_idx = 0; m_terr = 0;
        m_launch = -100; m_finish = -1; m_zdone = -1;
    endfunction

    // Advance the model across one edge using the inputs of cycle m_c.
    function automatic void m_step(input bit s, input int n, input bit a, input bit y);
        int c;
        bit waiting;
        c = m_c;
        waiting = m_act && (c > m_launch) && (m_finish < 0);
        if (!m_act) begin
            if (s) begin
                if (n != 0) begin
                    m_act = 1; m_num = n; m_idx = 0; m_terr = 0;
                    m_launch = c + 1; m_finish = -1;
                end else begin
                    m_zdone = c + 1;
                end
            end
        end else if (a) begin
            m_act = 0;
        end else if (c == m_finish) begin
            m_act = 0;
        end else if (waiting) begin
            if (y) begin
                if (m_idx == m_num - 1) m_finish = c + 1;
                else begin
                    m_idx++;
                    m_launch = c + 1 + int'(GAP_CYC);
                end
            end else if (c - m_launch == int'(TIMEOUT)) begin
                m_terr = 1;
                m_act  = 0;
            end
        end
        m_c = c + 1;
    endfunction

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; num_tiles = '0; abort = 1'b0; sync_pulse = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if ({lane_start, busy, done, timeout_err} !== 4'b0000 || tile_idx !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ls=%b busy=%b done=%b terr=%b idx=%0d, want all 0",
                     lane_start, busy, done, timeout_err, tile_idx);
        end
        rst_n = 1'b1;
        idle(2);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_single_tile();
        int d0;
        d0 = done_cnt;
        tick(1'b1, 8'd1, 1'b0, 1'b0);          // cycle 1
        checks++;
        if (lane_start !== 1'b1 || busy !== 1'b1 || tile_idx !== 8'd0) begin
            errors++;
            $display("FAIL single_launch: got ls=%b busy=%b idx=%0d, want 1 1 0",
                     lane_start, busy, tile_idx);
        end
        idle(1);                                 // cycle 2
        checks++;
        if (lane_start !== 1'b0) begin
            errors++;
            $display("FAIL single_ls_width: got ls=%b, want 0", lane_start);
        end
        idle(3);                                 // cycle 5
        tick(1'b0, '0, 1'b0, 1'b1);             // sync in cycle 5 -> cycle 6
        checks++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_done: got done=%b busy=%b, want 1 1", done, busy);
        end
        idle(1);                                 // cycle 7
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL single_end: got done=%b busy=%b dones=%0d, want 0 0 1",
                     done, busy, done_cnt - d0);
        end
    endtask

    task automatic test_three_tiles();
        int l0, d0;
        l0 = lane_cnt; d0 = done_cnt;
        tick(1'b1, 8'd3, 1'b0, 1'b0);
        for (int t = 0; t < 3; t++) begin
            // Here: 1 cycle after start, or 3 cycles after the previous sync.
            checks++;
            if (lane_start !== 1'b1 || tile_idx !== 8'(t)) begin
                errors++;
                $display("FAIL three_launch%0d: got ls=%b idx=%0d, want 1 %0d",
                         t, lane_start, tile_idx, t);
            end
            idle(1);
            tick(1'b0, '0, 1'b0, 1'b1);
            if (t < 2) begin
                checks++;
                if (tile_idx !== 8'(t + 1) || lane_start !== 1'b0) begin
                    errors++;
                    $display("FAIL three_step%0d: got idx=%0d ls=%b, want %0d 0",
                             t, tile_idx, lane_start, t + 1);
                end
                idle(1);
                checks++;
                if (lane_start !== 1'b0) begin
                    errors++;
                    $display("FAIL three_gap%0d: got ls=%b, want 0", t, lane_start);
                end
                idle(1);
            end
        end
        checks++;
        if (done !== 1'b1 || tile_idx !== 8'd2) begin
            errors++;
            $display("FAIL three_done: got done=%b idx=%0d, want 1 2", done, tile_idx);
        end
        idle(2);
        checks++;
        if (lane_cnt - l0 != 3 || done_cnt - d0 != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL three_counts: got lanes=%0d dones=%0d busy=%b, want 3 1 0",
                     lane_cnt - l0, done_cnt - d0, busy);
        end
    endtask

    task automatic test_timeout();
        int d0;
        d0 = done_cnt;
        tick(1'b1, 8'd2, 1'b0, 1'b0);
        idle(TIMEOUT);                           // last WAIT cycle
        checks++;
        if (timeout_err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early: got terr=%b busy=%b, want 0 1", timeout_err, busy);
        end
        idle(1);
        checks++;
        if (timeout_err !== 1'b1 || busy !== 1'b0 || done_cnt != d0) begin
            errors++;
            $display("FAIL timeout_fire: got terr=%b busy=%b dones=%0d, want 1 0 0",
                     timeout_err, busy, done_cnt - d0);
        end
        idle(3);
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: got terr=%b, want 1", timeout_err);
        end
        tick(1'b1, 8'd2, 1'b0, 1'b0);
        checks++;
        if (timeout_err !== 1'b0 || lane_start !== 1'b1) begin
            errors++;
            $display("FAIL timeout_clear: got terr=%b ls=%b, want 0 1", timeout_err, lane_start);
        end
        tick(1'b0, '0, 1'b1, 1'b0);
        idle(1);
    endtask

    task automatic test_collisions();
        int d0;
        d0 = done_cnt;
        tick(1'b1, 8'd3, 1'b0, 1'b0);
        idle(1);
        tick(1'b0, '0, 1'b1, 1'b1);             // abort + sync in WAIT
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || tile_idx !== 8'd0 || lane_start !== 1'b0) begin
            errors++;
            $display("FAIL abort_vs_sync: got busy=%b done=%b idx=%0d ls=%b, want 0 0 0 0",
                     busy, done, tile_idx, lane_start);
        end
        idle(4);
        checks++;
        if (done_cnt != d0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet: got dones=%0d busy=%b, want 0 0", done_cnt - d0, busy);
        end
        tick(1'b1, 8'd2, 1'b0, 1'b0);
        idle(TIMEOUT);
        tick(1'b0, '0, 1'b0, 1'b1);             // sync on expiry cycle
        checks++;
        if (timeout_err !== 1'b0 || busy !== 1'b1 || tile_idx !== 8'd1) begin
            errors++;
            $display("FAIL expiry_sync: got terr=%b busy=%b idx=%0d, want 0 1 1",
                     timeout_err, busy, tile_idx);
        end
        idle(2);
        checks++;
        if (lane_start !== 1'b1) begin
            errors++;
            $display("FAIL expiry_relaunch: got ls=%b, want 1", lane_start);
        end
        idle(1);
        tick(1'b0, '0, 1'b0, 1'b1);
        checks++;
        if (done !== 1'b1 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL expiry_done: got done=%b terr=%b, want 1 0", done, timeout_err);
        end
        idle(1);
    endtask

    task automatic test_idle_misuse();
        int l0, d0;
        l0 = lane_cnt; d0 = done_cnt;
        tick(1'b1, 8'd0, 1'b0, 1'b0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || lane_start !== 1'b0) begin
            errors++;
            $display("FAIL zero_tiles: got done=%b busy=%b ls=%b, want 1 0 0",
                     done, busy, lane_start);
        end
        idle(2);
        checks++;
        if (done !== 1'b0 || lane_cnt != l0 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL zero_tiles_after: got done=%b lanes=%0d dones=%0d, want 0 0 1",
                     done, lane_cnt - l0, done_cnt - d0);
        end
        l0 = lane_cnt; d0 = done_cnt;
        tick(1'b1, 8'd2, 1'b0, 1'b0);
        idle(1);
        tick(1'b1, 8'd5, 1'b0, 1'b0);           // start while busy
        checks++;
        if (tile_idx !== 8'd0 || lane_start !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_start: got idx=%0d ls=%b busy=%b, want 0 0 1",
                     tile_idx, lane_start, busy);
        end
        tick(1'b0, '0, 1'b0, 1'b1);
        tick(1'b0, '0, 1'b0, 1'b1);             // stray sync in SETTLE
        checks++;
        if (tile_idx !== 8'd1) begin
            errors++;
            $display("FAIL settle_sync: got idx=%0d, want 1", tile_idx);
        end
        idle(1);
        checks++;
        if (lane_start !== 1'b1 || tile_idx !== 8'd1) begin
            errors++;
            $display("FAIL settle_relaunch: got ls=%b idx=%0d, want 1 1", lane_start, tile_idx);
        end
        idle(1);
        tick(1'b0, '0, 1'b0, 1'b1);             // second tile is the last one
        checks++;
        if (done !== 1'b1 || lane_cnt - l0 != 2) begin
            errors++;
            $display("FAIL busy_no_resample: got done=%b lanes=%0d, want 1 2",
                     done, lane_cnt - l0);
        end
        idle(1);
    endtask

    task automatic test_reset_mid_pass();
        int d0;
        tick(1'b1, 8'd4, 1'b0, 1'b0);
        idle(1);
        tick(1'b0, '0, 1'b0, 1'b1);             // now in SETTLE, tile 1
        d0 = done_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({lane_start, busy, done, timeout_err} !== 4'b0000 || tile_idx !== '0) begin
            errors++;
            $display("FAIL reset_mid: got ls=%b busy=%b done=%b terr=%b idx=%0d, want all 0",
                     lane_start, busy, done, timeout_err, tile_idx);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(1'b1, 8'd4, 1'b0, 1'b0);
        checks++;
        if (lane_start !== 1'b1 || tile_idx !== 8'd0 || busy !== 1'b1 || done_cnt != d0) begin
            errors++;
            $display("FAIL reset_restart: got ls=%b idx=%0d busy=%b dones=%0d, want 1 0 1 0",
                     lane_start, tile_idx, busy, done_cnt - d0);
        end
        tick(1'b0, '0, 1'b1, 1'b0);
        idle(1);
    endtask

    task automatic test_random();
        int sync_pct;
        bit s, a, y;
        int n;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_reset();
        for (int i = 0; i < 4000; i++) begin
            if (i % 500 == 0) sync_pct = (i / 500) % 3 == 0 ? 3 : ((i / 500) % 3 == 1 ? 25 : 60);
            s = ($urandom_range(0, 99) < 15);
            n = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 5);
            a = ($urandom_range(0, 199) < 2);
            y = ($urandom_range(0, 99) < sync_pct);
            m_step(s, n, a, y);
            tick(s, 8'(n), a, y);
            checks++;
            if (lane_start !== (m_act && m_c == m_launch)) begin
                errors++;
                $display("FAIL rand_lane_start cyc=%0d: got %b, want %b",
                         m_c, lane_start, m_act && m_c == m_launch);
            end
            checks++;
            if (done !== ((m_act && m_c == m_finish) || m_c == m_zdone)) begin
                errors++;
                $display("FAIL rand_done cyc=%0d: got %b, want %b",
                         m_c, done, (m_act && m_c == m_finish) || m_c == m_zdone);
            end
            checks++;
            if (busy !== m_act) begin
                errors++;
                $display("FAIL rand_busy cyc=%0d: got %b, want %b", m_c, busy, m_act);
            end
            checks++;
            if (tile_idx !== 8'(m_idx)) begin
                errors++;
                $display("FAIL rand_tile_idx cyc=%0d: got %0d, want %0d", m_c, tile_idx, m_idx);
            end
            checks++;
            if (timeout_err !== m_terr) begin
                errors++;
                $display("FAIL rand_timeout_err cyc=%0d: got %b, want %b",
                         m_c, timeout_err, m_terr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_tile();
        test_three_tiles();
        test_timeout();
        test_collisions();
        test_idle_misuse();
        test_reset_mid_pass();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/q_tile_sequencer.md
Q_TILE_SEQUENCER -- requirements
Module: q_tile_sequencer

Interface
REQ-001 The block SHALL expose the following parameters:
- CNT_W, default 8, width of the tile count and tile index.
- GAP_CYC, default 2, idle cycles between an accepted sync_pulse and the next lane_start (minimum 1).
- TIMEOUT, default 1024, WAIT-state cycles before a timeout is declared.

REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with the following ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, single-cycle request to run one projection pass.
- num_tiles, input, CNT_W, tiles per pass; sampled only when start is accepted.
- abort, input, 1, cancels the pass in progress.
- sync_pulse, input, 1, single-cycle all-lanes-finished pulse from the four-input pulse synchronizer.
- lane_start, output, 1, single-cycle launch pulse broadcast to all four lanes.
- tile_idx, output, CNT_W, index of the tile currently issued.
- busy, output, 1, high in every state except IDLE.
- done, output, 1, single-cycle pass-complete pulse.
- timeout_err, output, 1, sticky watchdog flag.

Function
REQ-003 All outputs SHALL be registered.

REQ-004 The state machine SHALL have exactly these states: IDLE, ISSUE, WAIT, SETTLE, FINISH.

REQ-005 IDLE: start=1 with num_tiles!=0 SHALL latch num_tiles, set tile_idx=0, clear timeout_err, and enter ISSUE.

REQ-006 IDLE: start=1 with num_tiles==0 SHALL pulse done for one cycle in the next cycle, leave timeout_err unchanged, and remain in IDLE.

REQ-007 ISSUE SHALL last exactly one cycle with lane_start=1, clear the watchdog counter, then enter WAIT; lane_start SHALL be 0 in every other state.

REQ-008 Start-to-launch latency: start accepted at edge N SHALL produce lane_start high during the cycle following edge N.

REQ-009 WAIT, sync_pulse=1, tile_idx==latched_num-1: SHALL enter FINISH.

REQ-010 WAIT, sync_pulse=1, otherwise: SHALL increment tile_idx and enter SETTLE.

REQ-011 SETTLE SHALL last exactly GAP_CYC cycles, then enter ISSUE.

REQ-012 FINISH SHALL last one cycle with done=1, then enter IDLE; done SHALL be 0 elsewhere, except as required by REQ-006.

REQ-013 The watchdog SHALL count each cycle spent in WAIT without sync_pulse; when the count reaches TIMEOUT-1, timeout_err SHALL set, the FSM SHALL enter IDLE, and done SHALL NOT pulse.

REQ-014 sync_pulse in the same cycle the watchdog expires SHALL take priority: the tile is treated as completed, and no timeout occurs.

REQ-015 sync_pulse in any state other than WAIT SHALL be ignored.

REQ-016 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, with no done and no lane_start; tile_idx SHALL hold its value.

REQ-017 abort SHALL take priority over sync_pulse and the watchdog in the same cycle.

REQ-018 start while busy=1 SHALL be ignored, and num_tiles SHALL NOT be re-sampled.

REQ-019 The tile_idx increment SHALL never wrap: the maximum pass is 2^CNT_W-1 tiles, and the last index is latched_num-1.

REQ-020 timeout_err SHALL clear only when a start is accepted with num_tiles!=0, or on reset.

Reset
REQ-021 rst_n=0 SHALL asynchronously force IDLE, clear the watchdog, clear the latched count, and drive lane_start=0, tile_idx=0, busy=0, done=0, timeout_err=0.

REQ-022 Reset asserted mid-pass SHALL abandon the pass with no done pulse; after rst_n rises, the first edge SHALL sample inputs normally.

Verification
REQ-023 The bench SHALL cover at least these directed scenarios:
- Single-tile pass: start with num_tiles=1 -> lane_start in cycle 1; sync_pulse in cycle 5 -> done in cycle 6, then busy=0 in cycle 7.
- Three-tile pass with GAP_CYC=2: lane_start pulses exactly 3 times; tile_idx steps 0,1,2; each lane_start comes 3 cycles after the preceding sync_pulse; exactly 1 done.
- Timeout with TIMEOUT=16: no sync_pulse after lane_start -> timeout_err=1 after 16 WAIT cycles, no done; the next start with num_tiles=2 clears timeout_err.
- Collisions: sync_pulse and abort in the same WAIT cycle -> IDLE, no done; sync_pulse in the expiry cycle -> no timeout_err, the pass continues.
- Idle and busy misuse: start with num_tiles=0 -> done in the next cycle, lane_start never asserts; start during WAIT and a stray sync_pulse in SETTLE -> tile_idx and the lane_start count are unchanged.
- Reset in SETTLE of tile 1 of 4 -> all outputs are 0 immediately; a subsequent start runs a clean pass from tile_idx=0.
